// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the runtime-programmable serial pattern detector.
// The optional match counter is enabled by defining SEQ_DET_COUNT_EN.
package seq_det_pkg;

    localparam int unsigned SEQ_DET_MAX_LEN = 8;
    localparam int unsigned SEQ_DET_CNT_W   = 16;
    localparam int unsigned SEQ_DET_MASK_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } seq_det_state_e;

    // Mask with the low 'len' bits set; callers cast it down to their pattern width.
    function automatic logic [SEQ_DET_MASK_W-1:0] len_mask(input int unsigned len);
        if (len >= SEQ_DET_MASK_W) begin
            return '1;
        end
        return (SEQ_DET_MASK_W'(1) << len) - SEQ_DET_MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial stream, configuration and result signals of the pattern detector.
// master drives stream/config (monitor side); slave is the detector.
interface seq_detector_param_if
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_DET_MAX_LEN,
    parameter int unsigned CNT_W   = SEQ_DET_CNT_W
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap_en;
    logic               clr_count;
    logic               detected;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output in, in_valid, cfg_load, pattern, pat_len, overlap_en, clr_count,
        input  detected, match_count
    );

    modport slave (
        input  in, in_valid, cfg_load, pattern, pat_len, overlap_en, clr_count,
        output detected, match_count
    );

endinterface

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module seq_det_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control and gapped input.
// Define SEQ_DET_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = SEQ_DET_MAX_LEN,
    parameter int unsigned CNT_W   = SEQ_DET_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] cfg_pat_q, cfg_pat_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic               cfg_ovl_q, cfg_ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    seq_det_state_e     state_q, state_d;
    logic               detected_q;

    logic               accept_c;
    logic               match_c;
    logic [MAX_LEN-1:0] mask_c;

    assign accept_c = bus.in_valid && !bus.cfg_load;
    assign mask_c   = MAX_LEN'(len_mask(32'(cfg_len_q)));

    // Next config/history/fill; a match compares the post-shift history under the length mask.
    always_comb begin
        cfg_pat_d = cfg_pat_q;
        cfg_len_d = cfg_len_q;
        cfg_ovl_d = cfg_ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_c   = 1'b0;

        if (bus.cfg_load) begin
            cfg_pat_d = bus.pattern;
            cfg_len_d = (bus.pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.pat_len;
            cfg_ovl_d = bus.overlap_en;
            hist_d    = '0;
            fill_d    = '0;
        end else if (accept_c) begin
            hist_d = {hist_q[MAX_LEN-2:0], bus.in};
            if (fill_q != LEN_W'(MAX_LEN)) begin
                fill_d = fill_q + LEN_W'(1);
            end
            if ((state_q != IDLE) && (fill_d >= cfg_len_q) &&
                (((hist_d ^ cfg_pat_q) & mask_c) == '0)) begin
                match_c = 1'b1;
                // Non-overlap mode demands a full fresh pattern before the next hit.
                if (!cfg_ovl_q) begin
                    fill_d = '0;
                end
            end
        end

        if (cfg_len_d == '0) begin
            state_d = IDLE;
        end else if (fill_d < cfg_len_d) begin
            state_d = FILL;
        end else begin
            state_d = ARMED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pat_q  <= '0;
            cfg_len_q  <= '0;
            cfg_ovl_q  <= 1'b1;
            hist_q     <= '0;
            fill_q     <= '0;
            state_q    <= IDLE;
            detected_q <= 1'b0;
        end else begin
            cfg_pat_q  <= cfg_pat_d;
            cfg_len_q  <= cfg_len_d;
            cfg_ovl_q  <= cfg_ovl_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            state_q    <= state_d;
            detected_q <= match_c;
        end
    end

    assign bus.detected = detected_q;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] count_w;

    seq_det_sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (bus.clr_count),
        .inc_i   (match_c),
        .count_o (count_w)
    );

    assign bus.match_count = count_w;
`else
    assign bus.match_count = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised, runtime-programmable serial pattern detector. It generalises the fixed 1011 detector: the pattern, its length (1..MAX_LEN) and overlap/non-overlap mode are all loadable at run time, and input bits may arrive with gaps. It sits on a single-bit serial stream in the protocol-monitor path and reports a registered one-cycle match pulse plus an optional saturating match count.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(MAX_LEN+1), width of pat_len
- CNT_W, 16, width of match_count
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- in  in  1  serial data bit
- in_valid  in  1  in is sampled only when high
- cfg_load  in  1  load pattern/pat_len/overlap_en into config registers
- pattern  in  MAX_LEN  pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last
- pat_len  in  LEN_W  pattern length; 0 disables detection; values above MAX_LEN are clamped to MAX_LEN
- overlap_en  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- clr_count  in  1  synchronous clear of match_count
- detected  out  1  one-cycle match pulse, registered
- match_count  out  CNT_W  saturating count of matches

## Operation
- Config registers cfg_pat, cfg_len, cfg_ovl are loaded only on cfg_load. Reset values are 0, 0, 1.
- History shift register hist[MAX_LEN-1:0]: on an accepted bit, hist <= {hist[MAX_LEN-2:0], in}.
- Fill counter fill (0..MAX_LEN, saturating) counts accepted bits since the last clear.
- FSM states:
  - IDLE: cfg_len==0.
  - FILL: fill < cfg_len.
  - ARMED: fill ≥ cfg_len.
  - State is derived from cfg_len and fill and updates every cycle.
- Match condition: an accepted bit, next-fill ≥ cfg_len, and the low cfg_len bits of next-hist equal the low cfg_len bits of cfg_pat. No match is possible in IDLE.
- On a match with cfg_ovl=1, fill is kept, so the next match can share bits with this one.
- On a match with cfg_ovl=0, fill is cleared to 0. A full cfg_len new bits are then required before the next match. hist is not cleared.
- cfg_load clears hist and fill. match_count is unaffected.
- If cfg_load and in_valid are high in the same cycle, cfg_load wins and the bit is discarded.
- Accepted bit means in_valid=1 and cfg_load=0. When in_valid=0, hist, fill and detected do not advance, and detected is 0.

## Timing
- Reset values: detected=0, match_count=0, hist=0, fill=0, config registers as listed under Operation, state IDLE.
- Latency: detected is high for exactly the one cycle following the clock edge that samples the final pattern bit.
- Back-to-back matches, possible with pat_len=1 or in overlap mode, give detected high on consecutive cycles.
- match_count increments on the same edge that sets detected. It saturates at 2^CNT_W-1.
- If clr_count and a match occur in the same cycle, clear wins and match_count becomes 0.
- When rst asserts mid-sequence, all state returns to reset values immediately. The partial sequence is lost and the pattern must be reprogrammed.

## Configuration
- SEQ_DET_COUNT_EN:
  - Defined: the saturating match counter and the clr_count logic are built.
  - Undefined: match_count is tied to 0, clr_count is ignored, and no counter flops are inferred. detected behaviour is identical in both builds.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE, FILL, ARMED)
  - the default MAX_LEN and CNT_W localparams
  - a mask function that builds the low-cfg_len bit mask
- One sub-module, seq_det_sat_counter: parametrised saturating counter with synchronous clear and increment, instantiated only under SEQ_DET_COUNT_EN.

## Test plan
- Pattern 4'b1011, len 4, overlap 1; stream 1,0,1,1,0,1,1 -> detected pulses after bits 4 and 7; match_count=2.
- Same stream, overlap 0 -> a single pulse after bit 4; match_count=1.
- Pattern 3'b111, len 3, overlap 1; five 1s -> pulses after bits 3, 4, 5 on consecutive cycles. With overlap 0 the same stream gives one pulse after bit 3.
- Pattern 1011 with in_valid low for 3 cycles between every bit -> one pulse, one cycle after the 4th valid bit. detected is 0 during the gaps.
- Stream 1,0,1, then rst pulse, then reprogram pattern 1011 and send 1 -> no pulse. After a fresh 1,0,1,1 -> pulse. Reset values are checked while rst is high.
- CNT_W=2, pattern len 1 (pattern 1), six 1s -> match_count saturates at 3. Then assert clr_count together with a match -> match_count=0. pat_len=0 with any stream -> no pulses.
